m_dram_arbiter: RTL

//  Two-hart DRAM request arbiter between the per-hart CPU/MMU clusters and the single DRAM controller.

---
 rtl/m_dram_arbiter.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/m_dram_arbiter.sv
// Two-hart DRAM request arbiter: latches each hart's one-cycle load/store
// pulse, serialises the latched requests round-robin to a single DRAM
// controller and routes read data and busy back to the requesting hart.
module m_dram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ACK_TO = 4    // 1..15 cycles to wait for m_busy to rise
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic [ADDR_W-1:0] h0_addr,
    input  logic [DATA_W-1:0] h0_wdata,
    input  logic [2:0]        h0_ctrl,
    input  logic              h0_we,
    input  logic              h0_le,
    output logic [DATA_W-1:0] h0_odata,
    output logic              h0_busy,
    input  logic [ADDR_W-1:0] h1_addr,
    input  logic [DATA_W-1:0] h1_wdata,
    input  logic [2:0]        h1_ctrl,
    input  logic              h1_we,
    input  logic              h1_le,
    output logic [DATA_W-1:0] h1_odata,
    output logic              h1_busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_ctrl,
    output logic              m_we,
    output logic              m_le,
    input  logic [DATA_W-1:0] m_odata,
    input  logic              m_busy,
    output logic              grant,
    output logic              active
);

    localparam int NH = 2;
    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    // Per-hart request inputs gathered into packed arrays (index = hart)
    logic [NH-1:0][ADDR_W-1:0] req_addr;
    logic [NH-1:0][DATA_W-1:0] req_wdata;
    logic [NH-1:0][2:0]        req_ctrl;
    logic [NH-1:0]             req_we;
    logic [NH-1:0]             req_le;
    logic [NH-1:0]             req_any;
    logic [NH-1:0]             cap;

    // Latched requests, one slot per hart
    logic [NH-1:0][ADDR_W-1:0] lat_addr_q;
    logic [NH-1:0][DATA_W-1:0] lat_wdata_q;
    logic [NH-1:0][2:0]        lat_ctrl_q;
    logic [NH-1:0]             lat_wr_q;
    logic [NH-1:0]             pend_q, pend_d;
    logic [NH-1:0]             clr;
    logic [NH-1:0][DATA_W-1:0] odata_q;

    // Arbitration / controller-side state
    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic              sel;
    logic              done;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [2:0]        m_ctrl_q, m_ctrl_d;

    assign req_addr  = {h1_addr, h0_addr};
    assign req_wdata = {h1_wdata, h0_wdata};
    assign req_ctrl  = {h1_ctrl, h0_ctrl};
    assign req_we    = {h1_we, h0_we};
    assign req_le    = {h1_le, h0_le};
    assign req_any   = req_we | req_le;

    // A pulse is only accepted into an empty slot; repeats while pending are dropped
    assign cap = req_any & ~pend_q;

    // Completion frees the slot of the hart being served
    assign clr    = done ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign pend_d = (pend_q | cap) & ~clr;

    // Latch the request of each hart whose slot is free
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_ctrl_q  <= '0;
            lat_wr_q    <= '0;
        end else begin
            for (int i = 0; i < NH; i++) begin
                if (cap[i]) begin
                    lat_addr_q[i]  <= req_addr[i];
                    lat_wdata_q[i] <= req_wdata[i];
                    lat_ctrl_q[i]  <= req_ctrl[i];
                    lat_wr_q[i]    <= req_we[i];   // store wins when both pulse
                end
            end
        end
    end

    // State register for the FSM and the held controller-side fields
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;       // hart0 wins the first tie
            cnt_q     <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_ctrl_q  <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_ctrl_q  <= m_ctrl_d;
        end
    end

    // Next-state: round-robin grant, one-cycle issue, ack timeout, completion
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_ctrl_d  = m_ctrl_q;
        done      = 1'b0;
        sel       = grant_q;
        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    sel       = (&pend_q) ? ~last_q : pend_q[1];
                    grant_d   = sel;
                    // Loaded here so the fields are on the bus during ISSUE
                    m_addr_d  = lat_addr_q[sel];
                    m_wdata_d = lat_wdata_q[sel];
                    m_ctrl_d  = lat_ctrl_q[sel];
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (m_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(ACK_TO - 1)) begin
                    // Controller never acknowledged: retire the request anyway
                    done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!m_busy) done = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        if (done) begin
            last_d  = grant_q;
            state_d = S_IDLE;
        end
    end

    // Read data returns to the served hart only for loads
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            odata_q <= '0;
        end else if (done && !lat_wr_q[grant_q]) begin
            odata_q[grant_q] <= m_odata;
        end
    end

    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_ctrl   = m_ctrl_q;
    assign m_we     = (state_q == S_ISSUE) &  lat_wr_q[grant_q];
    assign m_le     = (state_q == S_ISSUE) & ~lat_wr_q[grant_q];
    assign grant    = grant_q;
    assign active   = (state_q != S_IDLE);
    assign h0_busy  = req_any[0] | pend_q[0];
    assign h1_busy  = req_any[1] | pend_q[1];
    assign h0_odata = odata_q[0];
    assign h1_odata = odata_q[1];

endmodule
